// File: rtl/pwm_servo_if.sv
// Control/status bundle between the PIO-facing software side and the servo PWM generator.
interface pwm_servo_if;
  logic        enable;
  logic [15:0] duty_in;
  logic        pwm_out;
  logic        period_start;
  logic [15:0] active_duty;
  logic        duty_clamped;
  logic        running;

  modport master (
    output enable, duty_in,
    input  pwm_out, period_start, active_duty, duty_clamped, running
  );

  modport slave (
    input  enable, duty_in,
    output pwm_out, period_start, active_duty, duty_clamped, running
  );
endinterface

// File: rtl/pwm_servo_gen.sv
// Servo-style PWM generator: clock prescaler to a tick, fixed-length period counter,
// and a pulse-width register reloaded only at period boundaries so pulses never glitch.
module pwm_servo_gen #(
  parameter int CLK_DIV      = 50,
  parameter int PERIOD_TICKS = 20000,
  parameter int MIN_PULSE    = 1000,
  parameter int MAX_PULSE    = 2000
) (
  input  logic       clk,
  input  logic       reset,
  pwm_servo_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   pcnt_q, pcnt_d;
  logic [15:0]   active_q, active_d;
  logic          clamped_q, clamped_d;
  logic          pstart_q, pstart_d;
  logic          pwm_q, pwm_d;
  logic          tick, boundary, reload;
  logic [15:0]   duty_c;

  function automatic logic [15:0] clamp(input logic [15:0] d);
    if (d == '0)               return '0;
    if (d < 16'(MIN_PULSE))    return 16'(MIN_PULSE);
    if (d > 16'(MAX_PULSE))    return 16'(MAX_PULSE);
    return d;
  endfunction

  assign duty_c   = clamp(bus.duty_in);
  assign tick     = (state_q != IDLE) && (presc_q == PW'(CLK_DIV - 1));
  assign boundary = tick && (pcnt_q == 16'(PERIOD_TICKS - 1));

  always_comb begin
    // NOTE: every _d has a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    active_d  = active_q;
    clamped_d = clamped_q;
    pstart_d  = 1'b0;
    reload    = 1'b0;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        pcnt_d  = '0;
        if (bus.enable) begin
          state_d = RUN;
          reload  = 1'b1;
        end
      end
      RUN, DRAIN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (boundary)  pcnt_d = '0;
        else if (tick) pcnt_d = pcnt_q + 16'(1);

        // A draining generator stops only at the end of its period, never mid-pulse.
        if (boundary && (state_q == DRAIN) && !bus.enable) begin
          state_d = IDLE;
        end else begin
          state_d = bus.enable ? RUN : DRAIN;
          reload  = boundary;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      active_d  = duty_c;
      clamped_d = (duty_c != bus.duty_in);
      pstart_d  = 1'b1;
    end

    pwm_d = (state_d != IDLE) && (pcnt_d < active_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      pcnt_q    <= '0;
      active_q  <= '0;
      clamped_q <= 1'b0;
      pstart_q  <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q   <= state_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      active_q  <= active_d;
      clamped_q <= clamped_d;
      pstart_q  <= pstart_d;
      pwm_q     <= pwm_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = pstart_q;
  assign bus.active_duty  = active_q;
  assign bus.duty_clamped = clamped_q;
  assign bus.running      = (state_q != IDLE);
endmodule

// File: tb/tb_pwm_servo_gen.sv
// Bench for pwm_servo_gen: a clock-position model checked every cycle plus
// directed periods with hand-computed pulse widths and clamp results.
module tb_pwm_servo_gen;
  localparam int CLK_DIV      = 2;
  localparam int PERIOD_TICKS = 10;
  localparam int MIN_PULSE    = 2;
  localparam int MAX_PULSE    = 8;
  localparam int PER_CLKS     = CLK_DIV * PERIOD_TICKS;

  typedef struct {
    int          at;
    logic [15:0] duty;
    logic        en;
  } act_t;

  localparam act_t NO_ACT = '{at: -1, duty: 16'd0, en: 1'b0};

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  pwm_servo_if bus ();

  pwm_servo_gen #(
    .CLK_DIV      (CLK_DIV),
    .PERIOD_TICKS (PERIOD_TICKS),
    .MIN_PULSE    (MIN_PULSE),
    .MAX_PULSE    (MAX_PULSE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Model: position in the period counted in raw clocks, widths in ticks scaled by CLK_DIV.
  bit m_run = 0, m_drain = 0, m_pstart = 0, m_clamped = 0, m_pwm = 0;
  int m_t = 0, m_active = 0;

  function automatic int ref_clamp(input int d);
    if (d == 0)         return 0;
    if (d < MIN_PULSE)  return MIN_PULSE;
    if (d > MAX_PULSE)  return MAX_PULSE;
    return d;
  endfunction

  task automatic model_reload();
    m_active  = ref_clamp(int'(bus.duty_in));
    m_clamped = (m_active != int'(bus.duty_in));
    m_pstart  = 1;
  endtask

  task automatic model_step();
    m_pstart = 0;
    if (!m_run) begin
      if (bus.enable) begin
        m_run   = 1;
        m_drain = 0;
        m_t     = 0;
        model_reload();
      end
    end else begin
      m_t++;
      if (m_t == PER_CLKS) begin
        m_t = 0;
        if (m_drain && !bus.enable) m_run = 0;
        else begin
          model_reload();
          m_drain = !bus.enable;
        end
      end else begin
        m_drain = !bus.enable;
      end
    end
    m_pwm = m_run && (m_t < m_active * CLK_DIV);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_drain = 0; m_pstart = 0; m_clamped = 0; m_pwm = 0;
      m_t = 0; m_active = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    check("cmp pwm_out",      bus.pwm_out,      m_pwm);
    check("cmp period_start", bus.period_start, m_pstart);
    check("cmp active_duty",  bus.active_duty,  m_active);
    check("cmp duty_clamped", bus.duty_clamped, m_clamped);
    check("cmp running",      bus.running,      m_run);
  end

  // Entered at the negedge where period_start is high; leaves at the next period's first negedge.
  task automatic run_period(input string nm, input int exp_active, input int exp_high,
                            input logic exp_next_ps, input act_t a1, input act_t a2);
    int hi = 0;
    check({nm, " period_start"}, bus.period_start, 1);
    check({nm, " active_duty"},  bus.active_duty,  exp_active);
    for (int i = 0; i < PER_CLKS; i++) begin
      hi += int'(bus.pwm_out);
      if (i == a1.at) begin bus.duty_in = a1.duty; bus.enable = a1.en; end
      if (i == a2.at) begin bus.duty_in = a2.duty; bus.enable = a2.en; end
      @(negedge clk);
    end
    check({nm, " high clks"}, hi, exp_high);
    check({nm, " next period_start"}, bus.period_start, exp_next_ps);
  endtask

  initial begin
    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.duty_in = 16'd0;
    repeat (2) @(negedge clk);
    check("rst pwm_out",      bus.pwm_out,      0);
    check("rst period_start", bus.period_start, 0);
    check("rst active_duty",  bus.active_duty,  0);
    check("rst duty_clamped", bus.duty_clamped, 0);
    check("rst running",      bus.running,      0);
    reset = 1'b0;
    @(negedge clk);
    check("idle running", bus.running, 0);

    bus.duty_in = 16'd5;
    bus.enable  = 1'b1;
    @(negedge clk);
    check("start latency pwm_out", bus.pwm_out, 1);
    check("start duty_clamped", bus.duty_clamped, 0);
    check("start running", bus.running, 1);

    run_period("p1", 5, 10, 1'b1, NO_ACT, NO_ACT);
    run_period("p2", 5, 10, 1'b1, '{at: 7, duty: 16'd3, en: 1'b1}, NO_ACT);
    run_period("p3", 3,  6, 1'b1, '{at: 2, duty: 16'd1, en: 1'b1}, NO_ACT);
    check("clamp low duty_clamped", bus.duty_clamped, 1);
    run_period("p4", 2,  4, 1'b1, '{at: 2, duty: 16'd12, en: 1'b1}, NO_ACT);
    check("clamp high duty_clamped", bus.duty_clamped, 1);
    run_period("p5", 8, 16, 1'b1, '{at: 2, duty: 16'd0, en: 1'b1}, NO_ACT);
    check("zero duty_clamped", bus.duty_clamped, 0);
    run_period("p6", 0,  0, 1'b1, '{at: 2, duty: 16'd5, en: 1'b1}, NO_ACT);

    // Disable mid-pulse: the period completes, then the generator idles.
    run_period("p7", 5, 10, 1'b0, '{at: 3, duty: 16'd5, en: 1'b0}, NO_ACT);
    check("drain done running", bus.running, 0);
    check("drain done pwm_out", bus.pwm_out, 0);
    repeat (5) @(negedge clk);
    check("idle holds active_duty", bus.active_duty, 5);
    check("idle no period_start", bus.period_start, 0);

    bus.enable = 1'b1;
    @(negedge clk);
    run_period("p8", 5, 10, 1'b1, '{at: 3, duty: 16'd3, en: 1'b0}, '{at: 15, duty: 16'd3, en: 1'b1});
    run_period("p9", 3,  6, 1'b1, '{at: 5, duty: 16'd4, en: 1'b0}, '{at: 19, duty: 16'd4, en: 1'b1});
    run_period("p10", 4, 8, 1'b1, NO_ACT, NO_ACT);

    // Asynchronous reset in the middle of a high pulse.
    check("pre-reset pwm_out", bus.pwm_out, 1);
    #1 reset = 1'b1;
    #1;
    check("async rst pwm_out",      bus.pwm_out,      0);
    check("async rst running",      bus.running,      0);
    check("async rst active_duty",  bus.active_duty,  0);
    check("async rst period_start", bus.period_start, 0);
    bus.duty_in = 16'd8;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 50; p++) begin
      run_period("max", 8, 16, 1'b1, NO_ACT, NO_ACT);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
